// File: rtl/combo_sweep_seq_if.sv
// Host/evaluator bundle for the combinational sweep sequencer.
// master = host and evaluator side, slave = sequencer side.
interface combo_sweep_seq_if;
  logic        start;
  logic        abort;
  logic [15:0] expect_tt;
  logic        y;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic [15:0] truth_tt;
  logic [4:0]  err_cnt;
  logic        first_err_vld;
  logic [3:0]  first_err_idx;

  modport master (
    output start, abort, expect_tt, y,
    input  abcd, busy, done, truth_tt,
    input  err_cnt, first_err_vld, first_err_idx
  );

  modport slave (
    input  start, abort, expect_tt, y,
    output abcd, busy, done, truth_tt,
    output err_cnt, first_err_vld, first_err_idx
  );
endinterface

// File: rtl/combo_sweep_seq.sv
// Sweeps {A,B,C,D} over 0..LAST, samples Y after a settle window
// and records the truth table and mismatches against an expected table.
module combo_sweep_seq #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned LAST   = 15
) (
  input logic              clk,
  input logic              rst,
  combo_sweep_seq_if.slave bus
);

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);
  localparam logic [3:0] LAST_V   = 4'(LAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_FIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  vec;
  logic [3:0]  cnt;
  logic        sample;
  logic        launch;
  logic        miss;
  logic [15:0] truth_q;
  logic [4:0]  err_q;
  logic        fvld_q;
  logic [3:0]  fidx_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    launch    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          launch    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd0) begin
          sample = 1'b1;
          if (vec == LAST_V) state_nxt = S_FIN;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign miss = bus.y != bus.expect_tt[vec];

  always_ff @(posedge clk) begin
    if (rst) begin
      vec     <= 4'd0;
      cnt     <= 4'd0;
      truth_q <= 16'd0;
      err_q   <= 5'd0;
      fvld_q  <= 1'b0;
      fidx_q  <= 4'd0;
    end else if (launch) begin
      vec     <= 4'd0;
      cnt     <= SETTLE_V;
      truth_q <= 16'd0;
      err_q   <= 5'd0;
      fvld_q  <= 1'b0;
      fidx_q  <= 4'd0;
    end else if (sample) begin
      truth_q[vec] <= bus.y;
      if (miss) begin
        err_q <= err_q + 5'd1;
        if (!fvld_q) begin
          fvld_q <= 1'b1;
          fidx_q <= vec;
        end
      end
      // vec parks on LAST so it never wraps
      if (vec != LAST_V) vec <= vec + 4'd1;
      cnt <= SETTLE_V;
    end else if (state == S_DRIVE && !bus.abort) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign bus.abcd          = (state == S_DRIVE) ? vec : 4'd0;
  assign bus.busy          = state == S_DRIVE;
  assign bus.done          = state == S_FIN;
  assign bus.truth_tt      = truth_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_vld = fvld_q;
  assign bus.first_err_idx = fidx_q;

endmodule
